// File: rtl/dma_debug_tap.sv
// Passive two-channel DMA bus sniffer producing addr / nBytes / data debug words for a downstream ILA.
// Each channel tracks the running beat address, cumulative byte count, last data beat and protocol errors.

module dma_debug_tap_ch #(
    parameter int unsigned BEAT_BYTES = 8,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             req_valid_i,
    input  logic             req_ready_i,
    input  logic [31:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_beats_i,
    input  logic             beat_valid_i,
    input  logic             beat_ready_i,
    input  logic [63:0]      beat_data_i,
    output logic [31:0]      addr_o,
    output logic [63:0]      nbytes_o,
    output logic [63:0]      data_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam logic [31:0] BEAT_INC32 = 32'(BEAT_BYTES);
    localparam logic [63:0] BEAT_INC64 = 64'(BEAT_BYTES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] beats_left_q;
    logic [31:0]      addr_q;
    logic [63:0]      nbytes_q;
    logic [63:0]      data_q;
    logic             err_q;

    logic req_fire;
    logic beat_fire;
    logic last_beat;
    logic err_set;

    assign req_fire  = req_valid_i & req_ready_i;
    assign beat_fire = beat_valid_i & beat_ready_i;
    assign last_beat = (state_q == ST_BURST) && beat_fire && (beats_left_q == LEN_W'(1));

    // A request is only legal while idle or on the closing beat; any beat outside a burst is stray.
    assign err_set = ((state_q == ST_IDLE) && beat_fire) ||
                     ((state_q == ST_BURST) && req_fire && !last_beat);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            beats_left_q <= '0;
            addr_q       <= '0;
            nbytes_q     <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            if (beat_fire) begin
                data_q <= beat_data_i;
            end

            if (clr_i) begin
                nbytes_q <= beat_fire ? BEAT_INC64 : '0;
            end else if (beat_fire) begin
                nbytes_q <= nbytes_q + BEAT_INC64;
            end

            if (err_set) begin
                err_q <= 1'b1;
            end else if (clr_i) begin
                err_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        addr_q <= req_addr_i;
                        if (req_beats_i != '0) begin
                            beats_left_q <= req_beats_i;
                            state_q      <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (beat_fire) begin
                        addr_q       <= addr_q + BEAT_INC32;
                        beats_left_q <= beats_left_q - LEN_W'(1);
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    // Back-to-back request on the closing beat overrides the beat's address/count update.
                    if (req_fire && last_beat) begin
                        addr_q       <= req_addr_i;
                        beats_left_q <= req_beats_i;
                        state_q      <= (req_beats_i != '0) ? ST_BURST : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign addr_o   = addr_q;
    assign nbytes_o = nbytes_q;
    assign data_o   = data_q;
    assign busy_o   = (state_q == ST_BURST);
    assign err_o    = err_q;

endmodule

module dma_debug_tap #(
    parameter int unsigned BEAT_BYTES = 8,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             v_clk0,
    input  logic             v_rst0,
    input  logic             dbg_clr,
    input  logic             ch0_req_valid,
    input  logic             ch0_req_ready,
    input  logic [31:0]      ch0_req_addr,
    input  logic [LEN_W-1:0] ch0_req_beats,
    input  logic             ch0_beat_valid,
    input  logic             ch0_beat_ready,
    input  logic [63:0]      ch0_beat_data,
    input  logic             ch1_req_valid,
    input  logic             ch1_req_ready,
    input  logic [31:0]      ch1_req_addr,
    input  logic [LEN_W-1:0] ch1_req_beats,
    input  logic             ch1_beat_valid,
    input  logic             ch1_beat_ready,
    input  logic [63:0]      ch1_beat_data,
    output logic [31:0]      v_debug0_0,
    output logic [63:0]      v_debug0_1,
    output logic [63:0]      v_debug0_2,
    output logic             ch0_busy,
    output logic             ch0_err,
    output logic [31:0]      v_debug1_0,
    output logic [63:0]      v_debug1_1,
    output logic [63:0]      v_debug1_2,
    output logic             ch1_busy,
    output logic             ch1_err
);

    dma_debug_tap_ch #(
        .BEAT_BYTES (BEAT_BYTES),
        .LEN_W      (LEN_W)
    ) u_ch0 (
        .clk_i        (v_clk0),
        .rst_i        (v_rst0),
        .clr_i        (dbg_clr),
        .req_valid_i  (ch0_req_valid),
        .req_ready_i  (ch0_req_ready),
        .req_addr_i   (ch0_req_addr),
        .req_beats_i  (ch0_req_beats),
        .beat_valid_i (ch0_beat_valid),
        .beat_ready_i (ch0_beat_ready),
        .beat_data_i  (ch0_beat_data),
        .addr_o       (v_debug0_0),
        .nbytes_o     (v_debug0_1),
        .data_o       (v_debug0_2),
        .busy_o       (ch0_busy),
        .err_o        (ch0_err)
    );

    dma_debug_tap_ch #(
        .BEAT_BYTES (BEAT_BYTES),
        .LEN_W      (LEN_W)
    ) u_ch1 (
        .clk_i        (v_clk0),
        .rst_i        (v_rst0),
        .clr_i        (dbg_clr),
        .req_valid_i  (ch1_req_valid),
        .req_ready_i  (ch1_req_ready),
        .req_addr_i   (ch1_req_addr),
        .req_beats_i  (ch1_req_beats),
        .beat_valid_i (ch1_beat_valid),
        .beat_ready_i (ch1_beat_ready),
        .beat_data_i  (ch1_beat_data),
        .addr_o       (v_debug1_0),
        .nbytes_o     (v_debug1_1),
        .data_o       (v_debug1_2),
        .busy_o       (ch1_busy),
        .err_o        (ch1_err)
    );

endmodule

// File: tb/tb_dma_debug_tap.sv
// Bench for dma_debug_tap: directed scenarios plus randomized two-channel traffic against a transaction model.

module tb_dma_debug_tap;

    localparam int unsigned BB    = 8;
    localparam int unsigned LEN_W = 16;

    logic             v_clk0 = 1'b0;
    logic             v_rst0, dbg_clr;
    logic             ch0_req_valid, ch0_req_ready, ch0_beat_valid, ch0_beat_ready;
    logic             ch1_req_valid, ch1_req_ready, ch1_beat_valid, ch1_beat_ready;
    logic [31:0]      ch0_req_addr, ch1_req_addr;
    logic [LEN_W-1:0] ch0_req_beats, ch1_req_beats;
    logic [63:0]      ch0_beat_data, ch1_beat_data;
    logic [31:0]      v_debug0_0, v_debug1_0;
    logic [63:0]      v_debug0_1, v_debug0_2, v_debug1_1, v_debug1_2;
    logic             ch0_busy, ch0_err, ch1_busy, ch1_err;

    int checks   = 0;
    int failures = 0;

    // Transaction-level expectation per channel.
    bit          m_busy [2];
    int unsigned m_left [2];
    logic [31:0] m_addr [2];
    logic [63:0] m_nb   [2];
    logic [63:0] m_data [2];
    bit          m_err  [2];

    always #5 v_clk0 = ~v_clk0;

    dma_debug_tap #(.BEAT_BYTES(BB), .LEN_W(LEN_W)) dut (
        .v_clk0(v_clk0), .v_rst0(v_rst0), .dbg_clr(dbg_clr),
        .ch0_req_valid(ch0_req_valid), .ch0_req_ready(ch0_req_ready),
        .ch0_req_addr(ch0_req_addr), .ch0_req_beats(ch0_req_beats),
        .ch0_beat_valid(ch0_beat_valid), .ch0_beat_ready(ch0_beat_ready),
        .ch0_beat_data(ch0_beat_data),
        .ch1_req_valid(ch1_req_valid), .ch1_req_ready(ch1_req_ready),
        .ch1_req_addr(ch1_req_addr), .ch1_req_beats(ch1_req_beats),
        .ch1_beat_valid(ch1_beat_valid), .ch1_beat_ready(ch1_beat_ready),
        .ch1_beat_data(ch1_beat_data),
        .v_debug0_0(v_debug0_0), .v_debug0_1(v_debug0_1), .v_debug0_2(v_debug0_2),
        .ch0_busy(ch0_busy), .ch0_err(ch0_err),
        .v_debug1_0(v_debug1_0), .v_debug1_1(v_debug1_1), .v_debug1_2(v_debug1_2),
        .ch1_busy(ch1_busy), .ch1_err(ch1_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one clock worth of observed handshakes to the model of one channel.
    task automatic model_ch(input int ch, input bit rf, input logic [31:0] ra, input int unsigned rb,
                            input bit bf, input logic [63:0] bd);
        bit was_busy, ended, bad;
        if (v_rst0) begin
            m_busy[ch] = 0; m_left[ch] = 0; m_addr[ch] = '0;
            m_nb[ch] = '0; m_data[ch] = '0; m_err[ch] = 0;
            return;
        end
        was_busy = m_busy[ch];
        ended    = 0;
        bad      = 0;
        if (bf) begin
            m_data[ch] = bd;
            m_nb[ch]   = m_nb[ch] + 64'(BB);
            if (was_busy) begin
                m_addr[ch] = m_addr[ch] + 32'(BB);
                m_left[ch] = m_left[ch] - 1;
                if (m_left[ch] == 0) begin
                    m_busy[ch] = 0;
                    ended = 1;
                end
            end else begin
                bad = 1;
            end
        end
        if (rf) begin
            if (!was_busy || ended) begin
                m_addr[ch] = ra;
                m_left[ch] = rb;
                m_busy[ch] = (rb != 0);
            end else begin
                bad = 1;
            end
        end
        if (dbg_clr) m_nb[ch] = bf ? 64'(BB) : 64'd0;
        if (bad) m_err[ch] = 1;
        else if (dbg_clr) m_err[ch] = 0;
    endtask

    task automatic chk_all();
        chk("ch0_addr",   64'(v_debug0_0), 64'(m_addr[0]));
        chk("ch0_nbytes", v_debug0_1,      m_nb[0]);
        chk("ch0_data",   v_debug0_2,      m_data[0]);
        chk("ch0_busy",   64'(ch0_busy),   64'(m_busy[0]));
        chk("ch0_err",    64'(ch0_err),    64'(m_err[0]));
        chk("ch1_addr",   64'(v_debug1_0), 64'(m_addr[1]));
        chk("ch1_nbytes", v_debug1_1,      m_nb[1]);
        chk("ch1_data",   v_debug1_2,      m_data[1]);
        chk("ch1_busy",   64'(ch1_busy),   64'(m_busy[1]));
        chk("ch1_err",    64'(ch1_err),    64'(m_err[1]));
    endtask

    task automatic step();
        @(posedge v_clk0);
        model_ch(0, ch0_req_valid && ch0_req_ready, ch0_req_addr, int'(ch0_req_beats),
                 ch0_beat_valid && ch0_beat_ready, ch0_beat_data);
        model_ch(1, ch1_req_valid && ch1_req_ready, ch1_req_addr, int'(ch1_req_beats),
                 ch1_beat_valid && ch1_beat_ready, ch1_beat_data);
        #1;
        chk_all();
    endtask

    task automatic quiet();
        v_rst0 = 0; dbg_clr = 0;
        ch0_req_valid = 0; ch0_req_ready = 0; ch0_beat_valid = 0; ch0_beat_ready = 0;
        ch1_req_valid = 0; ch1_req_ready = 0; ch1_beat_valid = 0; ch1_beat_ready = 0;
        ch0_req_addr = '0; ch0_req_beats = '0; ch0_beat_data = '0;
        ch1_req_addr = '0; ch1_req_beats = '0; ch1_beat_data = '0;
    endtask

    task automatic req0(input logic [31:0] a, input int unsigned n);
        ch0_req_valid = 1; ch0_req_ready = 1; ch0_req_addr = a; ch0_req_beats = LEN_W'(n);
    endtask

    task automatic req1(input logic [31:0] a, input int unsigned n);
        ch1_req_valid = 1; ch1_req_ready = 1; ch1_req_addr = a; ch1_req_beats = LEN_W'(n);
    endtask

    task automatic beat0(input logic [63:0] d);
        ch0_beat_valid = 1; ch0_beat_ready = 1; ch0_beat_data = d;
    endtask

    task automatic beat1(input logic [63:0] d);
        ch1_beat_valid = 1; ch1_beat_ready = 1; ch1_beat_data = d;
    endtask

    task automatic randomize_inputs();
        dbg_clr = 1'($urandom);
        ch0_req_valid = 1'($urandom); ch0_req_ready = 1'($urandom);
        ch0_req_addr = $urandom; ch0_req_beats = LEN_W'($urandom);
        ch0_beat_valid = 1'($urandom); ch0_beat_ready = 1'($urandom);
        ch0_beat_data = {$urandom, $urandom};
        ch1_req_valid = 1'($urandom); ch1_req_ready = 1'($urandom);
        ch1_req_addr = $urandom; ch1_req_beats = LEN_W'($urandom);
        ch1_beat_valid = 1'($urandom); ch1_beat_ready = 1'($urandom);
        ch1_beat_data = {$urandom, $urandom};
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_busy[c] = 0; m_left[c] = 0; m_addr[c] = '0; m_nb[c] = '0; m_data[c] = '0; m_err[c] = 0;
        end
        quiet();
        @(negedge v_clk0);

        // Reset held two cycles under random traffic.
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            v_rst0 = 1;
            step();
        end
        chk("rst_addr0", 64'(v_debug0_0), 64'd0);
        chk("rst_busy1", 64'(ch1_busy), 64'd0);
        quiet();
        step();

        // Four-beat burst on ch0.
        req0(32'h1000, 4);
        step();
        chk("t2_busy_on", 64'(ch0_busy), 64'd1);
        quiet();
        for (int i = 1; i <= 4; i++) begin
            beat0(64'(i));
            step();
        end
        chk("t2_addr", 64'(v_debug0_0), 64'h1020);
        chk("t2_nbytes", v_debug0_1, 64'd32);
        chk("t2_data", v_debug0_2, 64'd4);
        chk("t2_busy_off", 64'(ch0_busy), 64'd0);
        quiet();

        // ch1 closing beat coincides with the next request.
        req1(32'h3000, 2);
        step();
        quiet();
        beat1(64'hA);
        step();
        beat1(64'hB);
        req1(32'h2000, 2);
        step();
        chk("t3_busy", 64'(ch1_busy), 64'd1);
        chk("t3_addr", 64'(v_debug1_0), 64'h2000);
        chk("t3_err", 64'(ch1_err), 64'd0);
        quiet();
        beat1(64'hC);
        step();
        beat1(64'hD);
        step();
        quiet();

        // Illegal request mid-burst, then a stray beat while idle.
        req0(32'h4000, 4);
        step();
        quiet();
        beat0(64'h11);
        step();
        quiet();
        req0(32'h5000, 1);
        step();
        chk("t4_err", 64'(ch0_err), 64'd1);
        chk("t4_addr", 64'(v_debug0_0), 64'h4008);
        quiet();
        for (int i = 0; i < 3; i++) begin
            beat0(64'(i + 32'h20));
            step();
        end
        quiet();
        dbg_clr = 1;
        step();
        chk("t4_clr_err", 64'(ch0_err), 64'd0);
        chk("t4_clr_nb", v_debug0_1, 64'd0);
        quiet();
        beat0(64'h99);
        step();
        chk("t4_idle_err", 64'(ch0_err), 64'd1);
        chk("t4_idle_nb", v_debug0_1, 64'd8);
        quiet();

        // Address wrap and clear coincident with a beat.
        req0(32'hFFFF_FFF8, 2);
        step();
        quiet();
        beat0(64'h1);
        step();
        chk("t5_wrap0", 64'(v_debug0_0), 64'h0);
        beat0(64'h2);
        dbg_clr = 1;
        step();
        chk("t5_wrap8", 64'(v_debug0_0), 64'h8);
        chk("t5_clr_nb", v_debug0_1, 64'd8);
        chk("t5_clr_err", 64'(ch0_err), 64'd0);
        quiet();

        // Zero-beat request only moves the address.
        req1(32'h7777_0000, 0);
        step();
        chk("t6_zero_busy", 64'(ch1_busy), 64'd0);
        chk("t6_zero_addr", 64'(v_debug1_0), 64'h7777_0000);
        quiet();

        // Randomized concurrent traffic with ready stalls.
        for (int i = 0; i < 600; i++) begin
            quiet();
            dbg_clr = ($urandom_range(0, 31) == 0);
            ch0_req_valid  = ($urandom_range(0, 5) == 0);
            ch0_req_ready  = ($urandom_range(0, 3) != 0);
            ch0_req_addr   = $urandom & 32'hFFFF_FFF8;
            ch0_req_beats  = LEN_W'($urandom_range(0, 5));
            ch0_beat_valid = m_busy[0] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            ch0_beat_ready = ($urandom_range(0, 2) != 0);
            ch0_beat_data  = {$urandom, $urandom};
            ch1_req_valid  = ($urandom_range(0, 5) == 0);
            ch1_req_ready  = ($urandom_range(0, 3) != 0);
            ch1_req_addr   = $urandom;
            ch1_req_beats  = LEN_W'($urandom_range(0, 5));
            ch1_beat_valid = m_busy[1] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            ch1_beat_ready = ($urandom_range(0, 2) != 0);
            ch1_beat_data  = {$urandom, $urandom};
            step();
        end

        // Reset abandons an in-flight burst.
        quiet();
        req0(32'h8000, 5);
        step();
        quiet();
        beat0(64'h5);
        step();
        v_rst0 = 1;
        beat0(64'h6);
        step();
        chk("rst_mid_busy", 64'(ch0_busy), 64'd0);
        chk("rst_mid_addr", 64'(v_debug0_0), 64'd0);
        quiet();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
